// File: rtl/pipe_mon_pkg.sv
// -----------------------------------------------------------------------------
// pipe_mon_pkg
// Shared definitions for the pipeline event monitor:
//   - event channel indices as wired from the hazard unit
//   - trace record field offsets ({stamp, event bits}, event bits at the LSBs)
//   - drop counter width and its saturation value
//   - FIFO operation encoding used by the trace FIFO
// -----------------------------------------------------------------------------
package pipe_mon_pkg;

  // Channel indices of the hazard unit strobes
  localparam int EVT_STALL  = 0;
  localparam int EVT_BRANCH = 1;
  localparam int EVT_FWD    = 2;
  localparam int EVT_FLUSH  = 3;

  // Trace record layout: event bits occupy the low bits, stamp sits above them
  localparam int REC_EVT_LSB = 0;

  // Drop counter width and the value it sticks at
  localparam int                 DROP_W   = 16;
  localparam logic [DROP_W-1:0]  DROP_MAX = 16'hFFFF;

  // Per-cycle FIFO operation, encoded as {pop, push}
  typedef enum logic [1:0] {
    FIFO_HOLD = 2'b00,
    FIFO_PUSH = 2'b01,
    FIFO_POP  = 2'b10,
    FIFO_BOTH = 2'b11
  } fifo_op_e;

  // Bit offset of the cycle stamp inside a record for a given channel count
  function automatic int rec_stamp_lsb(input int num_evt);
    return REC_EVT_LSB + num_evt;
  endfunction

endpackage

// File: rtl/pipe_mon_fifo.sv
// -----------------------------------------------------------------------------
// pipe_mon_fifo
// First-word-fall-through FIFO holding trace records.
// Pointers carry one extra wrap bit so full and empty are distinguishable
// without a separate counter; the occupancy is kept in its own register so
// the level output comes straight from a flop.
// Ports:
//   clk    in   clock
//   rstn   in   synchronous active-low reset
//   clr    in   synchronous clear (empties the FIFO)
//   push   in   write request; accepted when not full or when a pop frees a slot
//   pop    in   read request; ignored while empty
//   wdata  in   record to write
//   rdata  out  head record (valid while empty=0)
//   empty  out  no records stored
//   full   out  DEPTH records stored
//   level  out  occupancy, 0..DEPTH
// -----------------------------------------------------------------------------
module pipe_mon_fifo
  import pipe_mon_pkg::*;
#(
  parameter int WIDTH = 36,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     clr,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int         AW      = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wptr;
  logic [AW:0]      r_rptr;
  logic [AW:0]      r_level;

  logic             w_pop;
  logic             w_push;
  fifo_op_e         w_op;

  assign empty = (r_wptr == r_rptr);
  // Same slot index but different wrap bit means the writer is a full lap ahead
  assign full  = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);

  // A pop from an empty FIFO is meaningless; a push into a full FIFO only
  // proceeds when the same-cycle pop frees the head slot.
  assign w_pop  = pop & ~empty;
  assign w_push = push & (~full | w_pop);
  assign w_op   = fifo_op_e'({w_pop, w_push});

  assign rdata = r_mem[r_rptr[AW-1:0]];
  assign level = r_level;

  // Pointer and occupancy update
  always_ff @(posedge clk) begin
    if (!rstn || clr) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
    end else begin
      case (w_op)
        FIFO_PUSH: begin
          r_wptr  <= r_wptr + PTR_ONE;
          r_level <= r_level + PTR_ONE;
        end
        FIFO_POP: begin
          r_rptr  <= r_rptr + PTR_ONE;
          r_level <= r_level - PTR_ONE;
        end
        FIFO_BOTH: begin
          r_wptr  <= r_wptr + PTR_ONE;
          r_rptr  <= r_rptr + PTR_ONE;
        end
        default: begin
          r_wptr  <= r_wptr;
          r_rptr  <= r_rptr;
          r_level <= r_level;
        end
      endcase
    end
  end

  // Record storage; contents need no reset because empty masks stale entries
  always_ff @(posedge clk) begin
    if (rstn && !clr && w_push) begin
      r_mem[r_wptr[AW-1:0]] <= wdata;
    end
  end

endmodule

// File: rtl/pipe_event_monitor.sv
// -----------------------------------------------------------------------------
// pipe_event_monitor
// Taps the hazard unit strobes of the 5-stage core. Keeps one counter per
// event channel plus a free-running cycle counter, and logs cycle-stamped
// records of masked events into a trace FIFO drained over valid/ready.
// Ports:
//   clk        in   clock
//   rstn       in   synchronous active-low reset
//   en         in   enable; low freezes counters and suppresses trace pushes
//   clr        in   synchronous clear of all state (same effect as reset)
//   evt        in   one-cycle event strobes, bit i = channel i
//   trc_mask   in   channels eligible for tracing (counting ignores it)
//   cnt_sel    in   counter readback select
//   cnt_data   out  selected counter, 0 when cnt_sel is out of range
//   cycle      out  cycle counter
//   trc_valid  out  trace FIFO not empty
//   trc_ready  in   consumer takes the head record
//   trc_data   out  head record {stamp, masked event bits}
//   trc_level  out  FIFO occupancy
//   drop_cnt   out  records lost to a full FIFO, saturating
//   overflow   out  sticky, set on the first drop
// -----------------------------------------------------------------------------
module pipe_event_monitor
  import pipe_mon_pkg::*;
#(
  parameter int NUM_EVT    = 4,
  parameter int CNT_W      = 32,
  parameter int CYC_W      = 32,
  parameter int FIFO_DEPTH = 16,
  parameter int SATURATE   = 0
) (
  input  logic                          clk,
  input  logic                          rstn,
  input  logic                          en,
  input  logic                          clr,
  input  logic [NUM_EVT-1:0]            evt,
  input  logic [NUM_EVT-1:0]            trc_mask,
  input  logic [3:0]                    cnt_sel,
  output logic [CNT_W-1:0]              cnt_data,
  output logic [CYC_W-1:0]              cycle,
  output logic                          trc_valid,
  input  logic                          trc_ready,
  output logic [CYC_W+NUM_EVT-1:0]      trc_data,
  output logic [$clog2(FIFO_DEPTH):0]   trc_level,
  output logic [DROP_W-1:0]             drop_cnt,
  output logic                          overflow
);

  localparam int               REC_W     = CYC_W + NUM_EVT;
  localparam int               STAMP_LSB = rec_stamp_lsb(NUM_EVT);
  localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
  localparam logic [CYC_W-1:0] CYC_ONE   = {{(CYC_W-1){1'b0}}, 1'b1};

  logic [CNT_W-1:0]   r_cnt [NUM_EVT];
  logic [CYC_W-1:0]   r_cycle;
  logic [DROP_W-1:0]  r_drop;
  logic               r_overflow;

  logic [NUM_EVT-1:0] w_trc_bits;
  logic               w_push_req;
  logic               w_pop;
  logic               w_drop;
  logic               w_empty;
  logic               w_full;
  logic [REC_W-1:0]   w_rec;

  // Only masked channels go into the trace; all strobes of one cycle share a record
  assign w_trc_bits = evt & trc_mask;
  assign w_push_req = en & (|w_trc_bits);
  assign w_pop      = trc_valid & trc_ready;
  // A push into a full FIFO is lost unless a pop in the same cycle makes room
  assign w_drop     = w_push_req & w_full & ~w_pop;

  // Record assembly: stamp is the cycle count before this edge's increment
  always_comb begin
    w_rec = '0;
    w_rec[REC_EVT_LSB +: NUM_EVT] = w_trc_bits;
    w_rec[STAMP_LSB +: CYC_W]     = r_cycle;
  end

  // Per-channel event counters; SATURATE selects stick-at-max versus wrap
  always_ff @(posedge clk) begin
    if (!rstn || clr) begin
      for (int i = 0; i < NUM_EVT; i++) begin
        r_cnt[i] <= '0;
      end
    end else if (en) begin
      for (int i = 0; i < NUM_EVT; i++) begin
        if (!evt[i]) begin
          r_cnt[i] <= r_cnt[i];
        end else if ((SATURATE != 0) && (r_cnt[i] == CNT_MAX)) begin
          r_cnt[i] <= r_cnt[i];
        end else begin
          r_cnt[i] <= r_cnt[i] + CNT_ONE;
        end
      end
    end else begin
      for (int i = 0; i < NUM_EVT; i++) begin
        r_cnt[i] <= r_cnt[i];
      end
    end
  end

  // Free-running cycle counter; always wraps
  always_ff @(posedge clk) begin
    if (!rstn || clr) begin
      r_cycle <= '0;
    end else if (en) begin
      r_cycle <= r_cycle + CYC_ONE;
    end else begin
      r_cycle <= r_cycle;
    end
  end

  // Drop counter and sticky overflow flag
  always_ff @(posedge clk) begin
    if (!rstn || clr) begin
      r_drop     <= '0;
      r_overflow <= 1'b0;
    end else if (w_drop) begin
      r_drop     <= (r_drop == DROP_MAX) ? r_drop : (r_drop + 16'd1);
      r_overflow <= 1'b1;
    end else begin
      r_drop     <= r_drop;
      r_overflow <= r_overflow;
    end
  end

  // Counter readback mux; unselected or out-of-range selects read as zero
  always_comb begin
    cnt_data = '0;
    for (int i = 0; i < NUM_EVT; i++) begin
      if (cnt_sel == 4'(i)) begin
        cnt_data = r_cnt[i];
      end else begin
        cnt_data = cnt_data;
      end
    end
  end

  pipe_mon_fifo #(
    .WIDTH (REC_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rstn  (rstn),
    .clr   (clr),
    .push  (w_push_req),
    .pop   (trc_ready),
    .wdata (w_rec),
    .rdata (trc_data),
    .empty (w_empty),
    .full  (w_full),
    .level (trc_level)
  );

  assign trc_valid = ~w_empty;
  assign cycle     = r_cycle;
  assign drop_cnt  = r_drop;
  assign overflow  = r_overflow;

endmodule

// File: tb/tb_pipe_event_monitor.sv
`timescale 1ns/1ps
module tb_pipe_event_monitor;
  import pipe_mon_pkg::*;

  localparam int NE  = 4;
  localparam int CW  = 8;
  localparam int YW  = 32;
  localparam int DEP = 16;
  localparam int RW  = YW + NE;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          en = 1'b0;
  logic          clr = 1'b0;
  logic          trc_ready = 1'b0;
  logic [NE-1:0] evt = '0;
  logic [NE-1:0] trc_mask = '0;
  logic [3:0]    cnt_sel = 4'd0;

  logic [CW-1:0] cnt_data, cnt_data_s;
  logic [YW-1:0] cycle, cycle_s;
  logic          trc_valid, trc_valid_s;
  logic [RW-1:0] trc_data, trc_data_s;
  logic [4:0]    trc_level, trc_level_s;
  logic [15:0]   drop_cnt, drop_cnt_s;
  logic          overflow, overflow_s;

  // Wrapping instance and saturating instance share all inputs
  pipe_event_monitor #(.NUM_EVT(NE), .CNT_W(CW), .CYC_W(YW), .FIFO_DEPTH(DEP), .SATURATE(0)) dut (
    .clk(clk), .rstn(rstn), .en(en), .clr(clr), .evt(evt), .trc_mask(trc_mask),
    .cnt_sel(cnt_sel), .cnt_data(cnt_data), .cycle(cycle), .trc_valid(trc_valid),
    .trc_ready(trc_ready), .trc_data(trc_data), .trc_level(trc_level),
    .drop_cnt(drop_cnt), .overflow(overflow));

  pipe_event_monitor #(.NUM_EVT(NE), .CNT_W(CW), .CYC_W(YW), .FIFO_DEPTH(DEP), .SATURATE(1)) dut_s (
    .clk(clk), .rstn(rstn), .en(en), .clr(clr), .evt(evt), .trc_mask(trc_mask),
    .cnt_sel(cnt_sel), .cnt_data(cnt_data_s), .cycle(cycle_s), .trc_valid(trc_valid_s),
    .trc_ready(trc_ready), .trc_data(trc_data_s), .trc_level(trc_level_s),
    .drop_cnt(drop_cnt_s), .overflow(overflow_s));

  always #10 clk = ~clk;

  // Reference model state
  int            m_cnt [NE];
  int            m_cnt_s [NE];
  longint        m_cycle;
  int            m_level;
  int            m_drop;
  int            m_ovf;
  logic [RW-1:0] exp_q [$];

  int n_vec = 0;
  int n_err = 0;

  function automatic void chk(input string name, input longint act, input longint exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endfunction

  // Effect of the coming clock edge, from the behavioural rules
  task automatic model_step();
    int            pop;
    logic [NE-1:0] bits;
    if (!rstn || clr) begin
      for (int i = 0; i < NE; i++) begin
        m_cnt[i] = 0;
        m_cnt_s[i] = 0;
      end
      m_cycle = 0; m_level = 0; m_drop = 0; m_ovf = 0;
      exp_q.delete();
    end else begin
      pop  = (trc_ready && m_level > 0) ? 1 : 0;
      bits = evt & trc_mask;
      if (en) begin
        if (bits != '0) begin
          if (m_level < DEP || pop == 1) begin
            exp_q.push_back({m_cycle[YW-1:0], bits});
            m_level++;
          end else begin
            m_drop = (m_drop < 65535) ? m_drop + 1 : 65535;
            m_ovf  = 1;
          end
        end
        for (int i = 0; i < NE; i++) begin
          if (evt[i]) begin
            m_cnt[i]   = (m_cnt[i] + 1) % (1 << CW);
            m_cnt_s[i] = (m_cnt_s[i] < (1 << CW) - 1) ? m_cnt_s[i] + 1 : (1 << CW) - 1;
          end
        end
        m_cycle = (m_cycle + 1) % (64'd1 << YW);
      end
      m_level -= pop;
    end
  endtask

  // Drive one cycle of inputs, step the model, then check registered outputs
  task automatic cyc(input logic i_rstn, input logic i_en, input logic i_clr,
                     input logic [NE-1:0] i_evt, input logic [NE-1:0] i_mask,
                     input logic i_ready);
    rstn = i_rstn; en = i_en; clr = i_clr; evt = i_evt; trc_mask = i_mask;
    trc_ready = i_ready & i_rstn & ~i_clr;
    model_step();
    @(posedge clk);
    #1;
    chk("cycle", cycle, m_cycle);
    chk("trc_level", trc_level, m_level);
    chk("trc_valid", trc_valid, (m_level > 0) ? 1 : 0);
    chk("drop_cnt", drop_cnt, m_drop);
    chk("overflow", overflow, m_ovf);
    chk("cycle_s", cycle_s, m_cycle);
    chk("trc_level_s", trc_level_s, m_level);
    chk("drop_cnt_s", drop_cnt_s, m_drop);
  endtask

  // Sweep the readback select, including out-of-range values
  task automatic check_cnts();
    int sels [6] = '{0, 1, 2, 3, 4, 15};
    foreach (sels[k]) begin
      cnt_sel = 4'(sels[k]);
      #1;
      chk($sformatf("cnt%0d", sels[k]), cnt_data, (sels[k] < NE) ? m_cnt[sels[k]] : 0);
      chk($sformatf("cnt_s%0d", sels[k]), cnt_data_s, (sels[k] < NE) ? m_cnt_s[sels[k]] : 0);
    end
  endtask

  // Scoreboard monitor: a handshake seen here pops on the next rising edge
  always @(negedge clk) begin
    logic [RW-1:0] e;
    if (trc_valid && trc_ready) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL trc_pop: unexpected record %h, none expected", trc_data);
      end else begin
        e = exp_q.pop_front();
        chk("trc_data", trc_data, e);
        chk("trc_data_s", trc_data_s, e);
      end
    end
  end

  initial begin
    logic [NE-1:0] one_hot_stall;
    logic [RW-1:0] exp_rec;
    logic          r_c, r_r;
    one_hot_stall = '0;
    one_hot_stall[EVT_STALL] = 1'b1;

    // Reset state
    repeat (2) cyc(1'b0, 1'b1, 1'b0, 4'hF, 4'hF, 1'b0);
    check_cnts();

    // Count stall events with full trace mask
    repeat (10) cyc(1'b1, 1'b1, 1'b0, one_hot_stall, 4'hF, 1'b0);
    check_cnts();
    chk("t1_cycle", cycle, 10);
    chk("t1_level", trc_level, 10);

    // Frozen monitor: events ignored, consumer drains stamps 0..9
    repeat (12) cyc(1'b1, 1'b0, 1'b0, 4'hF, 4'hF, 1'b1);
    check_cnts();

    // Trace stamp after 5 idle cycles
    cyc(1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 1'b0);
    repeat (5) cyc(1'b1, 1'b1, 1'b0, 4'h0, 4'b0010, 1'b0);
    cyc(1'b1, 1'b1, 1'b0, 4'b1010, 4'b0010, 1'b0);
    exp_rec = {32'd5, 4'b0010};
    chk("t2_valid", trc_valid, 1);
    chk("t2_data", trc_data, exp_rec);
    check_cnts();
    repeat (3) cyc(1'b1, 1'b1, 1'b0, 4'h0, 4'h0, 1'b1);

    // Overflow and drop, then full FIFO with simultaneous push and pop
    cyc(1'b1, 1'b1, 1'b1, 4'h0, 4'h0, 1'b0);
    repeat (20) cyc(1'b1, 1'b1, 1'b0, 4'b0100, 4'b0100, 1'b0);
    chk("t3_level", trc_level, 16);
    chk("t3_drop", drop_cnt, 4);
    chk("t3_ovf", overflow, 1);
    cyc(1'b1, 1'b1, 1'b0, 4'b0100, 4'b0100, 1'b1);
    chk("t4_level", trc_level, 16);
    chk("t4_drop", drop_cnt, 4);
    repeat (20) cyc(1'b1, 1'b0, 1'b0, 4'h0, 4'h0, 1'b1);

    // Clear coincident with events on every channel
    repeat (3) cyc(1'b1, 1'b1, 1'b0, 4'hF, 4'hF, 1'b0);
    cyc(1'b1, 1'b1, 1'b1, 4'hF, 4'hF, 1'b0);
    check_cnts();
    chk("t6_level", trc_level, 0);
    chk("t6_ovf", overflow, 0);

    // 300 events on an 8-bit counter: wrap versus saturate
    repeat (300) cyc(1'b1, 1'b1, 1'b0, one_hot_stall, 4'h0, 1'b0);
    check_cnts();
    cnt_sel = 4'd0;
    #1;
    chk("t5_wrap", cnt_data, 44);
    chk("t5_sat", cnt_data_s, 255);

    // Randomized traffic with occasional clears
    for (int n = 0; n < 600; n++) begin
      r_c = ($urandom_range(0, 99) == 0);
      r_r = ($urandom_range(0, 9) < 4);
      cyc(1'b1, ($urandom_range(0, 9) != 0), r_c, NE'($urandom), NE'($urandom), r_r & ~r_c);
      if (n % 50 == 49) check_cnts();
    end

    repeat (40) cyc(1'b1, 1'b0, 1'b0, 4'h0, 4'h0, 1'b1);
    chk("final_queue", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/pipe_event_monitor.md
# pipe_event_monitor

Synthesizable pipeline event monitor for the 5-stage CPU. Counts per-channel hazard events (stall, branch taken, forward, flush, plus spare channels) and a free-running cycle count. Pushes cycle-stamped event records into a trace FIFO drained over a valid/ready port. Sits beside the core in `comp` and taps the hazard unit's control strobes, so event logging works on silicon and in long regressions without `$display` traffic.

## Interface
- NUM_EVT, 4: number of event channels (1..16).
- CNT_W, 32: width of each event counter (8..64).
- CYC_W, 32: width of cycle counter and trace timestamp.
- FIFO_DEPTH, 16: trace FIFO entries; power of two, >= 2.
- SATURATE, 0: 1 = counters stick at all-ones; 0 = counters wrap.
- clk  in  1  clock; all state updates on the rising edge.
- rstn  in  1  reset, synchronous, active-low.
- en  in  1  monitor enable; low freezes all counters and suppresses trace pushes.
- clr  in  1  synchronous clear of counters, drop count, overflow flag and FIFO.
- evt  in  NUM_EVT  event strobes, one cycle per event, bit i = channel i.
- trc_mask  in  NUM_EVT  channels eligible for tracing; counting ignores the mask.
- cnt_sel  in  4  counter select for readback.
- cnt_data  out  CNT_W  combinational value of counter cnt_sel; 0 if cnt_sel >= NUM_EVT.
- cycle  out  CYC_W  cycle counter.
- trc_valid  out  1  trace FIFO non-empty.
- trc_ready  in  1  consumer accepts the head record.
- trc_data  out  CYC_W+NUM_EVT  head record {stamp, evt bits}; don't-care when trc_valid=0.
- trc_level  out  $clog2(FIFO_DEPTH)+1  FIFO occupancy.
- drop_cnt  out  16  records lost to a full FIFO; saturates at 0xFFFF.
- overflow  out  1  sticky; set on the first drop.

## Operation
- Reset (rstn=0 at an edge) sets all counters, cycle, drop_cnt, overflow and trc_level to 0 and trc_valid to 0. rstn overrides clr, en and all inputs. Reset mid-drain discards FIFO contents.
- clr=1 has the same effect as reset on every state element. clr beats events in the same cycle: those events are neither counted nor traced.
- Cycle counter increments by 1 each edge with en=1. It always wraps, independent of SATURATE.
- Counter i increments on each edge with en=1 and evt[i]=1.
  - SATURATE=0: wraps to 0 after all-ones.
  - SATURATE=1: holds all-ones.
- Trace push happens when en=1 and (evt & trc_mask) != 0. The record is {cycle value before this edge's increment, evt & trc_mask}. Multiple simultaneous events produce one record.
- Trace pop happens when trc_valid & trc_ready. The FIFO is first-word-fall-through.
- Full FIFO with push and no pop: the record is dropped, drop_cnt increments, and overflow is set.
- Full FIFO with push and pop in the same cycle: both happen and the level is unchanged. No drop.
- Empty FIFO with push and pop in the same cycle: the pop is invalid because trc_valid=0, so the push completes alone.
- trc_ready while empty is ignored.
- en=0 still allows pops, so the consumer can drain a frozen trace.

## Timing
- Counter and cycle outputs update one edge after the event is sampled. cnt_data follows cnt_sel combinationally.
- Event sampled at edge N: trc_valid/trc_data show the record after edge N. This is 1-cycle latency with an empty FIFO and no bypass in the same cycle.
- One push and one pop maximum per cycle, giving sustained throughput of 1 record/cycle.
- trc_data is held stable while trc_valid=1 and trc_ready=0.
- trc_level and overflow are registered. drop_cnt updates on the edge that drops.

## Structure
- Shared package `pipe_mon_pkg` holds:
  - channel indices: EVT_STALL=0, EVT_BRANCH=1, EVT_FWD=2, EVT_FLUSH=3;
  - record field offsets;
  - the drop_cnt width constant.
- One sub-module, `pipe_mon_fifo`:
  - parametrised width/depth;
  - FWFT;
  - pointers one bit wider than the address for the full/empty decision;
  - level output.
- Counters, cycle counter, push/drop logic and readback mux live in `pipe_event_monitor`.

## Test plan
- Reset/enable count:
  - Stimulus: reset, en=1, evt=4'b0001 for 10 cycles, then cnt_sel=0..3.
  - Required: cnt_data = 10, 0, 0, 0; cycle=10; trc_level=10 with trc_mask=4'hF.
- Trace stamp:
  - Stimulus: 5 idle cycles after reset, then evt=4'b1010 once, trc_mask=4'b0010.
  - Required: trc_data={32'd5, 4'b0010}, trc_valid high one cycle after the event; counters 1 and 3 each = 1.
- Overflow and drop:
  - Stimulus: FIFO_DEPTH=16, trc_ready=0, 20 consecutive traced events.
  - Required: trc_level=16, drop_cnt=4, overflow=1. Draining yields stamps 0..15 in order.
- Full with simultaneous push and pop:
  - Stimulus: FIFO full, then push and trc_ready=1 in the same cycle.
  - Required: level stays 16, drop_cnt unchanged, new record appears last.
- Saturate vs wrap:
  - Stimulus: CNT_W=8, 300 events.
  - Required: SATURATE=1 gives 255; SATURATE=0 gives 44.
- Clear priority and freeze:
  - Stimulus: clr=1 coincident with evt=4'hF; separately, en=0 with events pending.
  - Required: after clr, all counters 0, FIFO empty, overflow=0. With en=0, counters and cycle hold while pops still drain the FIFO.
